// File: rtl/signal_freq_meter.sv
// rtl/signal_freq_meter.sv - rising-edge frequency meter over a fixed clk-timed gate window
// Publishes the saturating edge count, a one-cycle strobe and an overflow flag per window.
module signal_freq_meter #(
  parameter int GATE_CYCLES = 100_000_000,
  parameter int COUNT_W     = 24
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               en,
  input  logic               sig_in,
  output logic [COUNT_W-1:0] freq,
  output logic               freq_valid,
  output logic               overflow
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]      G_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] E_MAX  = '1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state_q, state_d;

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;

  logic [GW-1:0]      gcnt_q, gcnt_d;
  logic [COUNT_W-1:0] ecnt_q, ecnt_d;
  logic               sat_q, sat_d;
  logic [COUNT_W-1:0] freq_q, freq_d;
  logic               valid_q, valid_d;
  logic               ovf_q, ovf_d;

  logic               edge_det;
  logic               win_end;
  logic [COUNT_W-1:0] ecnt_inc;
  logic               sat_inc;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      gcnt_q  <= '0;
      ecnt_q  <= '0;
      sat_q   <= 1'b0;
      freq_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      gcnt_q  <= gcnt_d;
      ecnt_q  <= ecnt_d;
      sat_q   <= sat_d;
      freq_q  <= freq_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  // An edge arriving at an already-full counter is the one that is lost, so it marks saturation.
  always_comb begin
    s1_d     = sig_in;
    s2_d     = s1_q;
    s3_d     = s2_q;
    edge_det = s2_q & ~s3_q;
    ecnt_inc = ecnt_q;
    sat_inc  = sat_q;
    if (edge_det) begin
      if (ecnt_q == E_MAX) begin
        sat_inc = 1'b1;
      end else begin
        ecnt_inc = ecnt_q + COUNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    ecnt_d  = ecnt_q;
    sat_d   = sat_q;
    freq_d  = freq_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    win_end = (state_q == RUN) && (gcnt_q == G_LAST);

    case (state_q)
      IDLE: begin
        gcnt_d = '0;
        ecnt_d = '0;
        sat_d  = 1'b0;
        if (en) begin
          state_d = RUN;
          gcnt_d  = GW'(1);
          ecnt_d  = ecnt_inc;
          sat_d   = sat_inc;
        end
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
          gcnt_d  = '0;
          ecnt_d  = '0;
          sat_d   = 1'b0;
        end else if (win_end) begin
          // The closing cycle's edge is folded into the published count, not the next window.
          gcnt_d  = '0;
          ecnt_d  = '0;
          sat_d   = 1'b0;
          freq_d  = ecnt_inc;
          ovf_d   = sat_inc;
          valid_d = 1'b1;
        end else begin
          gcnt_d = gcnt_q + GW'(1);
          ecnt_d = ecnt_inc;
          sat_d  = sat_inc;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign freq       = freq_q;
  assign freq_valid = valid_q;
  assign overflow   = ovf_q;

endmodule
